// File: rtl/instruction_fetch_if.sv
// Instruction fetch bus: the redirect controls and ROM handshake toward the
// fetch unit, plus the decode-side instruction, PC and stack status.
interface instruction_fetch_if #(
  parameter int INSTR_WIDTH = 28
);
  logic                   iStall;
  logic                   iBranchTaken;
  logic [15:0]            iBranchTarget;
  logic                   iCall;
  logic [15:0]            iCallTarget;
  logic                   iRet;
  logic [15:0]            oAddress;
  logic [INSTR_WIDTH-1:0] iInstruction;
  logic [INSTR_WIDTH-1:0] oInstruction;
  logic                   oInstructionValid;
  logic [15:0]            oPC;
  logic                   oStackOverflow;
  logic                   oStackUnderflow;

  // Fetch unit side.
  modport slave (
    input  iStall, iBranchTaken, iBranchTarget, iCall, iCallTarget, iRet,
    input  iInstruction,
    output oAddress, oInstruction, oInstructionValid, oPC,
    output oStackOverflow, oStackUnderflow
  );

  // Decode / ROM / control side.
  modport master (
    output iStall, iBranchTaken, iBranchTarget, iCall, iCallTarget, iRet,
    output iInstruction,
    input  oAddress, oInstruction, oInstructionValid, oPC,
    input  oStackOverflow, oStackUnderflow
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: a PC register addressing a combinational ROM, a
// one-stage instruction register toward decode, and a return-address stack.
// Any taken redirect squashes the word fetched in that cycle (one bubble).
module instruction_fetch #(
  parameter int STACK_DEPTH = 8,
  parameter int INSTR_WIDTH = 28
) (
  input  logic                Clock,
  input  logic                Reset,
  instruction_fetch_if.slave  bus
);

  localparam int AW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SPW = AW + 1;

  function automatic logic [15:0] inc16(input logic [15:0] a);
    return a + 16'd1;
  endfunction

  logic [15:0]            pc_p0;
  logic [15:0]            pc_next;
  logic [15:0]            pc_p1;
  logic [INSTR_WIDTH-1:0] instr_p1;
  logic                   vld_p1;
  logic [SPW-1:0]         sp;
  logic [SPW-1:0]         sp_next;
  logic                   ovf;
  logic                   ovf_next;
  logic                   unf;
  logic                   unf_next;
  logic                   redirect;
  logic                   push_en;
  logic [15:0]            push_data;
  logic [AW-1:0]          push_idx;
  logic [AW-1:0]          top_idx;
  logic [15:0]            stack_mem [STACK_DEPTH];

  // Next-PC selection (ret > call > branch > sequential) and stack bookkeeping.
  always_comb begin
    pc_next   = inc16(pc_p0);
    sp_next   = sp;
    ovf_next  = ovf;
    unf_next  = unf;
    redirect  = 1'b0;
    push_en   = 1'b0;
    push_data = inc16(pc_p1);
    push_idx  = AW'(sp);
    top_idx   = AW'(sp - SPW'(1));
    // Redirects describe the instruction in the output register, so a squashed
    // slot cannot redirect.
    if (vld_p1) begin
      if (bus.iRet) begin
        redirect = 1'b1;
        if (sp == SPW'(0)) begin
          pc_next  = 16'h0000;
          unf_next = 1'b1;
        end else begin
          pc_next = stack_mem[top_idx];
          sp_next = sp - SPW'(1);
        end
      end else if (bus.iCall) begin
        redirect = 1'b1;
        pc_next  = bus.iCallTarget;
        if (sp == SPW'(STACK_DEPTH)) begin
          ovf_next = 1'b1;
        end else begin
          push_en = 1'b1;
          sp_next = sp + SPW'(1);
        end
      end else if (bus.iBranchTaken) begin
        redirect = 1'b1;
        pc_next  = bus.iBranchTarget;
      end
    end
  end

  // PC, decode register, stack pointer and sticky flags; stall freezes all.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc_p0    <= 16'h0000;
      pc_p1    <= 16'h0000;
      instr_p1 <= '0;
      vld_p1   <= 1'b0;
      sp       <= '0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else if (!bus.iStall) begin
      // Stage p0 -> p1: ROM word and its address move to the decode register.
      instr_p1 <= bus.iInstruction;
      pc_p1    <= pc_p0;
      vld_p1   <= ~redirect;
      pc_p0    <= pc_next;
      sp       <= sp_next;
      ovf      <= ovf_next;
      unf      <= unf_next;
    end
  end

  // Return-address storage; contents are don't-care after reset.
  always_ff @(posedge Clock) begin
    if (!bus.iStall && push_en) begin
      stack_mem[push_idx] <= push_data;
    end
  end

  assign bus.oAddress          = pc_p0;
  assign bus.oInstruction      = instr_p1;
  assign bus.oInstructionValid = vld_p1;
  assign bus.oPC               = pc_p1;
  assign bus.oStackOverflow    = ovf;
  assign bus.oStackUnderflow   = unf;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios with literal expectations,
// plus a cycle-by-cycle comparison against a queue-based reference model.
module tb_instruction_fetch;

  localparam int IW    = 28;
  localparam int DEPTH = 8;

  logic Clock;
  logic Reset;
  int   checks;
  int   fails;

  instruction_fetch_if #(.INSTR_WIDTH(IW)) bus ();

  instruction_fetch #(.STACK_DEPTH(DEPTH), .INSTR_WIDTH(IW)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  function automatic logic [IW-1:0] rom(input logic [15:0] a);
    return {a ^ 16'h5A3C, 12'hC0D};
  endfunction

  assign bus.iInstruction = rom(bus.oAddress);

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: sequential behaviour expressed with a queue as the stack.
  logic [15:0]   m_pc;
  logic [15:0]   m_opc;
  logic [IW-1:0] m_instr;
  logic          m_vld;
  logic          m_ovf;
  logic          m_unf;
  logic [15:0]   m_stk[$];

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      m_pc = 16'h0000; m_opc = 16'h0000; m_instr = '0; m_vld = 1'b0;
      m_ovf = 1'b0; m_unf = 1'b0; m_stk.delete();
    end else if (!bus.iStall) begin
      logic [15:0] tgt;
      logic        redir;
      redir = m_vld && (bus.iRet || bus.iCall || bus.iBranchTaken);
      tgt   = m_pc + 16'd1;
      if (m_vld && bus.iRet) begin
        if (m_stk.size() == 0) begin tgt = 16'h0000; m_unf = 1'b1; end
        else tgt = m_stk.pop_back();
      end else if (m_vld && bus.iCall) begin
        if (m_stk.size() < DEPTH) m_stk.push_back(m_opc + 16'd1);
        else m_ovf = 1'b1;
        tgt = bus.iCallTarget;
      end else if (m_vld && bus.iBranchTaken) begin
        tgt = bus.iBranchTarget;
      end
      m_instr = rom(m_pc);
      m_opc   = m_pc;
      m_vld   = !redir;
      m_pc    = tgt;
    end
  end

  // Every settled cycle out of reset: DUT outputs against the model.
  always @(negedge Clock) begin
    if (Reset === 1'b1) begin
      chk("m_oAddress", {16'h0, bus.oAddress}, {16'h0, m_pc});
      chk("m_oPC", {16'h0, bus.oPC}, {16'h0, m_opc});
      chk("m_oInstruction", {4'h0, bus.oInstruction}, {4'h0, m_instr});
      chk("m_oInstructionValid", {31'h0, bus.oInstructionValid}, {31'h0, m_vld});
      chk("m_oStackOverflow", {31'h0, bus.oStackOverflow}, {31'h0, m_ovf});
      chk("m_oStackUnderflow", {31'h0, bus.oStackUnderflow}, {31'h0, m_unf});
    end
  end

  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic run_to_opc(input logic [15:0] v);
    int n;
    n = 0;
    while ((bus.oPC !== v || bus.oInstructionValid !== 1'b1) && n < 200) begin
      tick();
      n++;
    end
    chk("run_to_opc", {16'h0, bus.oPC}, {16'h0, v});
  endtask

  logic [15:0]   ret_exp [8];
  logic [15:0]   hold_a;
  logic [15:0]   hold_p;
  logic [IW-1:0] hold_i;

  initial begin
    checks = 0;
    fails  = 0;
    Reset = 1'b0;
    bus.iStall = 1'b0; bus.iBranchTaken = 1'b0; bus.iBranchTarget = 16'h0;
    bus.iCall = 1'b0; bus.iCallTarget = 16'h0; bus.iRet = 1'b0;
    #3;
    chk("rst_oAddress", {16'h0, bus.oAddress}, 32'h0);
    chk("rst_oValid", {31'h0, bus.oInstructionValid}, 32'h0);
    chk("rst_oPC", {16'h0, bus.oPC}, 32'h0);
    chk("rst_oInstruction", {4'h0, bus.oInstruction}, 32'h0);
    tick(); tick();
    Reset = 1'b1;

    // Sequential fetch from reset release.
    tick();
    chk("seq1_addr", {16'h0, bus.oAddress}, 32'h1);
    chk("seq1_opc", {16'h0, bus.oPC}, 32'h0);
    chk("seq1_vld", {31'h0, bus.oInstructionValid}, 32'h1);
    chk("seq1_instr", {4'h0, bus.oInstruction}, 32'h05A3CC0D);
    tick();
    chk("seq2_addr", {16'h0, bus.oAddress}, 32'h2);
    chk("seq2_opc", {16'h0, bus.oPC}, 32'h1);
    tick();
    chk("seq3_addr", {16'h0, bus.oAddress}, 32'h3);

    // Branch at oPC=13 to 9; a branch during the bubble is ignored.
    run_to_opc(16'd13);
    bus.iBranchTaken = 1'b1; bus.iBranchTarget = 16'd9;
    tick();
    chk("br_bubble_vld", {31'h0, bus.oInstructionValid}, 32'h0);
    chk("br_addr", {16'h0, bus.oAddress}, 32'd9);
    bus.iBranchTarget = 16'h0077;
    tick();
    bus.iBranchTaken = 1'b0;
    chk("br_opc", {16'h0, bus.oPC}, 32'd9);
    chk("br_vld", {31'h0, bus.oInstructionValid}, 32'h1);
    chk("br_ignored_addr", {16'h0, bus.oAddress}, 32'd10);

    // Call at oPC=11 to 18, return at oPC=20 back to 12.
    run_to_opc(16'd11);
    bus.iCall = 1'b1; bus.iCallTarget = 16'd18;
    tick();
    bus.iCall = 1'b0;
    chk("call_addr", {16'h0, bus.oAddress}, 32'd18);
    run_to_opc(16'd20);
    bus.iRet = 1'b1;
    tick();
    bus.iRet = 1'b0;
    chk("ret_addr", {16'h0, bus.oAddress}, 32'd12);
    chk("ret_bubble", {31'h0, bus.oInstructionValid}, 32'h0);
    tick();
    chk("ret_unf", {31'h0, bus.oStackUnderflow}, 32'h0);

    // Call then simultaneous call+ret: behaves as a bare return.
    bus.iCall = 1'b1; bus.iCallTarget = 16'h0040;
    tick();
    bus.iCall = 1'b0;
    tick();
    bus.iCall = 1'b1; bus.iCallTarget = 16'h0090; bus.iRet = 1'b1;
    tick();
    bus.iCall = 1'b0; bus.iRet = 1'b0;
    chk("callret_addr", {16'h0, bus.oAddress}, 32'd13);
    tick();

    // PC wrap from FFFF to 0000.
    bus.iBranchTaken = 1'b1; bus.iBranchTarget = 16'hFFFF;
    tick();
    bus.iBranchTaken = 1'b0;
    tick();
    chk("wrap_opc", {16'h0, bus.oPC}, 32'hFFFF);
    chk("wrap_addr", {16'h0, bus.oAddress}, 32'h0);

    // Stall with a branch held: everything frozen, branch never taken.
    hold_a = bus.oAddress; hold_p = bus.oPC; hold_i = bus.oInstruction;
    bus.iStall = 1'b1; bus.iBranchTaken = 1'b1; bus.iBranchTarget = 16'h0005;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_addr", {16'h0, bus.oAddress}, {16'h0, hold_a});
      chk("stall_opc", {16'h0, bus.oPC}, {16'h0, hold_p});
      chk("stall_instr", {4'h0, bus.oInstruction}, {4'h0, hold_i});
      chk("stall_vld", {31'h0, bus.oInstructionValid}, 32'h1);
    end
    bus.iStall = 1'b0; bus.iBranchTaken = 1'b0;
    tick();
    chk("unstall_addr", {16'h0, bus.oAddress}, 32'h1);
    chk("unstall_opc", {16'h0, bus.oPC}, 32'h0);

    // Nine nested calls starting at oPC=0, then nine returns.
    ret_exp[0] = 16'h0001;
    for (int i = 1; i < 8; i++) ret_exp[i] = 16'h0100 + 16'(i - 1) * 16'h0010 + 16'h0001;
    for (int i = 0; i < 9; i++) begin
      bus.iCall = 1'b1; bus.iCallTarget = 16'h0100 + 16'(i) * 16'h0010;
      tick();
      bus.iCall = 1'b0;
      tick();
      if (i == 7) chk("ovf_after8", {31'h0, bus.oStackOverflow}, 32'h0);
    end
    chk("ovf_after9", {31'h0, bus.oStackOverflow}, 32'h1);
    chk("call9_opc", {16'h0, bus.oPC}, 32'h0180);
    for (int j = 0; j < 8; j++) begin
      bus.iRet = 1'b1;
      tick();
      bus.iRet = 1'b0;
      chk("nested_ret", {16'h0, bus.oAddress}, {16'h0, ret_exp[7-j]});
      if (j == 0) chk("first_ret_lit", {16'h0, bus.oAddress}, 32'h0161);
      tick();
    end
    chk("unf_before9", {31'h0, bus.oStackUnderflow}, 32'h0);
    bus.iRet = 1'b1;
    tick();
    bus.iRet = 1'b0;
    chk("ret9_addr", {16'h0, bus.oAddress}, 32'h0);
    chk("ret9_unf", {31'h0, bus.oStackUnderflow}, 32'h1);
    tick();

    // Asynchronous reset pulse between edges while oPC=7.
    run_to_opc(16'd7);
    #1 Reset = 1'b0;
    #1;
    chk("arst_addr", {16'h0, bus.oAddress}, 32'h0);
    chk("arst_vld", {31'h0, bus.oInstructionValid}, 32'h0);
    chk("arst_ovf", {31'h0, bus.oStackOverflow}, 32'h0);
    chk("arst_unf", {31'h0, bus.oStackUnderflow}, 32'h0);
    #1 Reset = 1'b1;
    tick();
    chk("post_rst_opc", {16'h0, bus.oPC}, 32'h0);
    chk("post_rst_vld", {31'h0, bus.oInstructionValid}, 32'h1);
    chk("post_rst_addr", {16'h0, bus.oAddress}, 32'h1);
    tick();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter STACK_DEPTH, default 8, giving the number of return-address stack entries (power of two, 2..16).
REQ-002 The block SHALL have parameter INSTR_WIDTH, default 28, giving the instruction word width.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low.
REQ-004 The block SHALL have these ports:
- iStall  in  1  hold all state this cycle.
- iBranchTaken  in  1  redirect to iBranchTarget.
- iBranchTarget  in  16  jump/branch destination.
- iCall  in  1  push return address, redirect to iCallTarget.
- iCallTarget  in  16  subroutine address.
- iRet  in  1  pop return address, redirect to it.
- oAddress  out  16  fetch address to instruction ROM.
- iInstruction  in  INSTR_WIDTH  ROM data, combinational from oAddress.
- oInstruction  out  INSTR_WIDTH  registered instruction to decode.
- oInstructionValid  out  1  oInstruction is on the correct path.
- oPC  out  16  address of the instruction in oInstruction.
- oStackOverflow  out  1  sticky, call pushed while stack full.
- oStackUnderflow  out  1  sticky, return popped while stack empty.

Function
REQ-005 oAddress SHALL be driven directly from the internal PC register.
REQ-006 On each rising edge with iStall=0:
- oInstruction <= iInstruction.
- oPC <= PC.
- PC <= next PC.
REQ-007 Next PC priority SHALL be: iRet > iCall > iBranchTaken > PC+1.
REQ-008 PC+1 SHALL wrap from 16'hFFFF to 16'h0000 with no flag.
REQ-009 Redirect inputs SHALL refer to the instruction currently in oInstruction.
REQ-010 On any redirect the word fetched that cycle SHALL be squashed: oInstructionValid <= 0 for exactly one cycle (one-bubble penalty), then PC <= target.
REQ-011 With no redirect and iStall=0, oInstructionValid <= 1.
REQ-012 Redirect inputs SHALL be ignored while oInstructionValid=0.
REQ-013 iCall SHALL:
- push oPC+1 (16-bit wrap) onto the return stack;
- load PC <= iCallTarget.
REQ-014 iRet SHALL:
- pop the top of the return stack;
- load PC <= popped value.
REQ-015 iCall and iRet asserted together SHALL act as iRet alone (no push).
REQ-016 A call when the stack holds STACK_DEPTH entries SHALL:
- discard the push (existing entries unchanged);
- set oStackOverflow=1;
- still redirect PC to iCallTarget.
REQ-017 A return when the stack is empty SHALL:
- load PC <= 16'h0000;
- set oStackUnderflow=1;
- leave the pointer at 0.
REQ-018 Overflow and underflow flags SHALL clear only on reset.
REQ-019 With iStall=1, the following SHALL hold their values and all redirect inputs SHALL be ignored:
- PC, oInstruction, oPC, oInstructionValid;
- stack contents, stack pointer, flags.
REQ-020 iStall SHALL take priority over every other input.
REQ-021 The stack SHALL be LIFO, with the pointer counting 0..STACK_DEPTH.

Reset
REQ-022 While Reset=0, outputs SHALL take these values immediately, independent of Clock:
- PC=0, so oAddress=0;
- oInstruction=0;
- oPC=0;
- oInstructionValid=0;
- stack pointer=0;
- oStackOverflow=0, oStackUnderflow=0.
REQ-023 Stack entry contents SHALL be don't-care after reset.
REQ-024 The first rising edge after Reset deasserts SHALL capture ROM word 0 with oPC=0 and oInstructionValid=1.
REQ-025 Reset asserted mid-operation, including mid-stall or mid-redirect, SHALL abandon all state; nothing pending survives.

Verification
REQ-026 Reset release, iStall=0, no redirects -> oAddress 0,1,2,3 on consecutive cycles; oPC lags oAddress by one cycle; oInstructionValid=1 from the first edge.
REQ-027 oPC=13, iBranchTaken=1, iBranchTarget=9 -> next cycle oInstructionValid=0 and oAddress=9; following cycle oPC=9 and oInstructionValid=1.
REQ-028 oPC=11, iCall=1, iCallTarget=18 -> oAddress=18; then at oPC=20, iRet=1 -> oAddress=12, one bubble, stack empty.
REQ-029 Nine nested calls at STACK_DEPTH=8 -> oStackOverflow=1 after the ninth; eight returns yield the first eight return addresses in reverse order; a ninth return sets oStackUnderflow=1 and oAddress=0.
REQ-030 iStall=1 for 3 cycles with iBranchTaken=1 held -> all outputs constant; after release, PC resumes at the held PC+1 with no branch.
REQ-031 Reset pulsed low between edges while oPC=7 -> oAddress=0, oInstructionValid=0, and both flags 0 before the next edge.
